// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
//
// Integer register file with two write ports and a per-register load-pending
// scoreboard. Decode reads it through two combinational read ports.
//
//   Port A (write_enable/rd/result)            : ALU / writeback results
//   Port B (load_write_enable/load_rd/...)     : load returns, clears pending
//   Issue  (issue_enable/issue_rd)             : sets the pending bit of a load
//   Reads  (rs1/rs2 -> rd1/rd2, rs1/rs2_busy)  : combinational
//   pending_count                              : registered popcount of pending
//
// Parameters:
//   XLEN     : data width
//   AW       : address width, NREGS = 2**AW registers
//   ZERO_REG : 1 -> register 0 reads as zero, ignores writes and issues
//
// Optional feature macro:
//   REGFILE_BYPASS_EN : when defined, same-cycle writes are forwarded to the
//                       read ports and a same-cycle load return clears the
//                       busy flag seen by decode. When undefined, reads show
//                       the pre-edge state only.
//
// Reset is asynchronous and active high. While reset is high every write and
// issue is suppressed, including the forwarding paths.
// -----------------------------------------------------------------------------
module register_file_mp #(
    parameter int          XLEN     = 32,
    parameter int          AW       = 5,
    parameter int unsigned ZERO_REG = 32'd1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            write_enable,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] result,
    input  logic            load_write_enable,
    input  logic [AW-1:0]   load_rd,
    input  logic [XLEN-1:0] load_result,
    input  logic            issue_enable,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     pending_count
);

    localparam int            NREGS     = 32'd1 << AW;
    localparam int            NRD       = 32'd2;
    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

    // True when the address is the hardwired zero register.
    function automatic logic is_zero_addr(input logic [AW-1:0] addr);
        return (ZERO_REG != 32'd0) && (addr == ZERO_ADDR);
    endfunction

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    // Qualified strobes: reset and the zero register kill every action.
    logic wr_a_s;
    logic wr_b_s;
    logic iss_s;
    logic set_new_s;
    logic clr_new_s;

    assign wr_a_s = write_enable      & ~reset & ~is_zero_addr(rd);
    assign wr_b_s = load_write_enable & ~reset & ~is_zero_addr(load_rd);
    assign iss_s  = issue_enable      & ~reset & ~is_zero_addr(issue_rd);

    // A bit is newly set only if it was clear; it is newly cleared only if it
    // was set and no issue to the same register overrides the clear.
    assign set_new_s = iss_s & ~pend_q[issue_rd];
    assign clr_new_s = wr_b_s & pend_q[load_rd] & ~(iss_s & (issue_rd == load_rd));

    // Next-state for data and pending bits; port A beats port B, issue beats clear.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int i = 0; i < NREGS; i++) begin
            if (wr_a_s && (rd == AW'(i))) begin
                regs_d[i] = result;
            end else if (wr_b_s && (load_rd == AW'(i))) begin
                regs_d[i] = load_result;
            end else begin
                regs_d[i] = regs_q[i];
            end

            if (iss_s && (issue_rd == AW'(i))) begin
                pend_d[i] = 1'b1;
            end else if (wr_b_s && (load_rd == AW'(i))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Pending counter moves by at most one set and one clear per cycle.
    always_comb begin
        count_d = count_q + {{AW{1'b0}}, set_new_s} - {{AW{1'b0}}, clr_new_s};
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            pend_q  <= {NREGS{1'b0}};
            count_q <= {(AW + 1){1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    assign pending_count = count_q;

    // ------------------------------------------------------------------
    // Read ports, handled as a two-entry array so both share one code path.
    // ------------------------------------------------------------------
    logic [AW-1:0]   rs_s       [NRD];
    logic [XLEN-1:0] raw_rd_s   [NRD];
    logic            raw_busy_s [NRD];
    logic [XLEN-1:0] rd_s       [NRD];
    logic            busy_s     [NRD];

    assign rs_s[0] = rs1;
    assign rs_s[1] = rs2;

    // Raw read data and busy flag, with optional same-cycle forwarding.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            raw_rd_s[p]   = regs_q[rs_s[p]];
            raw_busy_s[p] = pend_q[rs_s[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_a_s && (rd == rs_s[p])) begin
                raw_rd_s[p] = result;
            end else if (wr_b_s && (load_rd == rs_s[p])) begin
                raw_rd_s[p] = load_result;
            end else begin
                raw_rd_s[p] = regs_q[rs_s[p]];
            end

            // A returning load frees its register for decode this cycle,
            // unless a new load to the same register issues at the same time.
            if (wr_b_s && (load_rd == rs_s[p]) && !(iss_s && (issue_rd == rs_s[p]))) begin
                raw_busy_s[p] = 1'b0;
            end else begin
                raw_busy_s[p] = pend_q[rs_s[p]];
            end
`endif
        end
    end

    // Zero register masking applied last so it also covers forwarded data.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            if (is_zero_addr(rs_s[p])) begin
                rd_s[p]   = {XLEN{1'b0}};
                busy_s[p] = 1'b0;
            end else begin
                rd_s[p]   = raw_rd_s[p];
                busy_s[p] = raw_busy_s[p];
            end
        end
    end

    assign rd1      = rd_s[0];
    assign rd2      = rd_s[1];
    assign rs1_busy = busy_s[0];
    assign rs2_busy = busy_s[1];

endmodule

// File: tb/tb_register_file_mp.sv
// -----------------------------------------------------------------------------
// tb_register_file_mp
//
// Self-checking bench for register_file_mp. A behavioural model of the
// register contents and pending bits computes the expected read data, busy
// flags and pending count whenever stimulus is driven; the expectation is
// pushed to a queue and popped for comparison once the outputs have settled.
// Works for builds with and without REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_register_file_mp;

    localparam int          XLEN     = 32;
    localparam int          AW       = 5;
    localparam int          NREGS    = 32;
    localparam int unsigned ZERO_REG = 32'd1;

    logic            clock;
    logic            reset;
    logic            write_enable;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] result;
    logic            load_write_enable;
    logic [AW-1:0]   load_rd;
    logic [XLEN-1:0] load_result;
    logic            issue_enable;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic [AW:0]     pending_count;

    register_file_mp #(
        .XLEN     (XLEN),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .write_enable      (write_enable),
        .rd                (rd),
        .result            (result),
        .load_write_enable (load_write_enable),
        .load_rd           (load_rd),
        .load_result       (load_result),
        .issue_enable      (issue_enable),
        .issue_rd          (issue_rd),
        .rs1               (rs1),
        .rs2               (rs2),
        .rd1               (rd1),
        .rd2               (rd2),
        .rs1_busy          (rs1_busy),
        .rs2_busy          (rs2_busy),
        .pending_count     (pending_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       note;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic [31:0] cnt;
    } exp_t;

    exp_t            exp_q[$];
    logic [31:0]     m_regs [NREGS];
    logic [NREGS-1:0] m_pend;
    int              n_checks;
    int              n_fail;

    // Single comparison point: counts and reports.
    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic zero_addr(input logic [AW-1:0] a);
        return (ZERO_REG != 32'd0) && (a == 5'd0);
    endfunction

    function automatic logic a_ok();
        return write_enable && !reset && !zero_addr(rd);
    endfunction

    function automatic logic b_ok();
        return load_write_enable && !reset && !zero_addr(load_rd);
    endfunction

    function automatic logic s_ok();
        return issue_enable && !reset && !zero_addr(issue_rd);
    endfunction

    function automatic logic [31:0] exp_read(input logic [AW-1:0] rs);
        if (zero_addr(rs)) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (a_ok() && rd == rs) return result;
        if (b_ok() && load_rd == rs) return load_result;
`endif
        return m_regs[rs];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs);
        if (zero_addr(rs)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (b_ok() && load_rd == rs && !(s_ok() && issue_rd == rs)) return 1'b0;
`endif
        return m_pend[rs];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
        m_pend = '0;
    endtask

    // Apply the inputs seen at a rising edge to the model.
    task automatic model_update();
        logic wa, wb, ss;
        wa = a_ok();
        wb = b_ok();
        ss = s_ok();
        if (reset) begin
            model_reset();
        end else begin
            if (wb) m_regs[load_rd] = load_result;
            if (wa) m_regs[rd] = result;
            if (wb && !(ss && issue_rd == load_rd)) m_pend[load_rd] = 1'b0;
            if (ss) m_pend[issue_rd] = 1'b1;
        end
    endtask

    task automatic push_expect(input string note);
        exp_t e;
        e.note = note;
        e.rd1  = exp_read(rs1);
        e.rd2  = exp_read(rs2);
        e.b1   = exp_busy(rs1);
        e.b2   = exp_busy(rs2);
        e.cnt  = $countones(m_pend);
        exp_q.push_back(e);
    endtask

    task automatic check_expect();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_value("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_value({e.note, "/rd1"}, rd1, e.rd1);
        check_value({e.note, "/rd2"}, rd2, e.rd2);
        check_value({e.note, "/rs1_busy"}, {31'd0, rs1_busy}, {31'd0, e.b1});
        check_value({e.note, "/rs2_busy"}, {31'd0, rs2_busy}, {31'd0, e.b2});
        check_value({e.note, "/pending_count"}, {26'd0, pending_count}, e.cnt);
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic do_cycle(input string note);
        push_expect(note);
        #1;
        check_expect();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle();
        write_enable      = 1'b0;
        load_write_enable = 1'b0;
        issue_enable      = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        rd = 5'd0; result = 32'd0; load_rd = 5'd0; load_result = 32'd0;
        issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        model_reset();

        #2;
        push_expect("reset_state");
        #1;
        check_expect();
        @(negedge clock);
        reset = 1'b0;

        // Write x5 and issue x8, then read back.
        write_enable = 1'b1; rd = 5'd5; result = 32'hDEADBEEF;
        issue_enable = 1'b1; issue_rd = 5'd8; rs1 = 5'd5; rs2 = 5'd8;
        do_cycle("wr_x5");
        idle();
        do_cycle("rd_x5");

        // Async reset mid-cycle with a write and an issue held on the inputs.
        #2;
        write_enable = 1'b1; rd = 5'd5; result = 32'h00000022;
        issue_enable = 1'b1; issue_rd = 5'd9; rs2 = 5'd9;
        reset = 1'b1;
        model_reset();
        push_expect("async_reset");
        #1;
        check_expect();
        @(posedge clock);
        model_update();
        @(negedge clock);
        push_expect("reset_hold");
        #1;
        check_expect();
        #1;
        result = 32'h00000011; issue_enable = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        model_update();
        @(negedge clock);
        idle();
        do_cycle("first_wr_after_reset");

        // Zero register: both ports and issue to x0.
        write_enable = 1'b1; rd = 5'd0; result = 32'h00001234;
        load_write_enable = 1'b1; load_rd = 5'd0; load_result = 32'h00001234;
        issue_enable = 1'b1; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        do_cycle("zero_wr");
        idle();
        do_cycle("zero_rd");

        // Dual-write conflict on x7 while x7 is pending.
        issue_enable = 1'b1; issue_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
        do_cycle("iss_x7");
        idle();
        write_enable = 1'b1; rd = 5'd7; result = 32'hAAAA0001;
        load_write_enable = 1'b1; load_rd = 5'd7; load_result = 32'hBBBB0002;
        do_cycle("dual_wr");
        idle();
        do_cycle("dual_rd");

        // Scoreboard sequence: issue x3, x4, x3, return x3, return x9.
        rs1 = 5'd3; rs2 = 5'd4;
        issue_enable = 1'b1; issue_rd = 5'd3; do_cycle("iss_x3");
        issue_rd = 5'd4;                       do_cycle("iss_x4");
        issue_rd = 5'd3;                       do_cycle("reiss_x3");
        idle();
        load_write_enable = 1'b1; load_rd = 5'd3; load_result = 32'h00000033;
        do_cycle("ld_x3");
        rs1 = 5'd9; load_rd = 5'd9; load_result = 32'h00000099;
        do_cycle("ld_x9");
        idle(); rs1 = 5'd3;
        do_cycle("sb_idle");

        // Issue and load return on x6 in the same cycle, x6 already pending.
        rs1 = 5'd6; rs2 = 5'd6;
        issue_enable = 1'b1; issue_rd = 5'd6; do_cycle("iss_x6");
        load_write_enable = 1'b1; load_rd = 5'd6; load_result = 32'h00000055;
        do_cycle("iss_ld_x6");
        idle();
        do_cycle("x6_rd");

        // Same-cycle write and read of x10.
        write_enable = 1'b1; rd = 5'd10; result = 32'h0F0F0F0F;
        rs1 = 5'd10; rs2 = 5'd10;
        do_cycle("bypass_wr");
        idle();
        do_cycle("bypass_rd");

        // Random traffic over a small address range to provoke collisions.
        for (int k = 0; k < 60; k++) begin
            write_enable      = 1'($urandom_range(0, 1));
            rd                = 5'($urandom_range(0, 7));
            result            = $urandom;
            load_write_enable = 1'($urandom_range(0, 1));
            load_rd           = 5'($urandom_range(0, 7));
            load_result       = $urandom;
            issue_enable      = 1'($urandom_range(0, 1));
            issue_rd          = 5'($urandom_range(0, 7));
            rs1               = 5'($urandom_range(0, 7));
            rs2               = 5'($urandom_range(0, 7));
            do_cycle("random");
        end
        idle();
        do_cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
